ghost_collision_ctrl: RTL and testbench

Consumer end of the ghost/player position interface. Each movement step it samples the player tile position and every ghost tile position. It detects a catch, either by landing on the same tile or by two sprites swapping tiles in one step. It then manages lives, freezes movement for a fixed number of steps, issues a one-cycle respawn strobe to the movers, and holds game-over until restart.

---
 rtl/ghost_collision_ctrl_pkg.sv | 22 ++
 rtl/ghost_collision_ctrl_tile_hit_cmp.sv | 23 ++
 rtl/ghost_collision_ctrl.sv | 139 +++++++++++++
 tb/tb_ghost_collision_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/ghost_collision_ctrl_pkg.sv
// ghost_collision_ctrl_pkg: shared state encodings, tile coordinate widths and helpers.
`ifndef WIDTH_LOG2
`define WIDTH_LOG2 10
`endif
`ifndef HEIGHT_LOG2
`define HEIGHT_LOG2 9
`endif

package ghost_collision_ctrl_pkg;
  localparam int WIDTH_LOG2  = `WIDTH_LOG2;
  localparam int HEIGHT_LOG2 = `HEIGHT_LOG2;

  typedef enum logic [1:0] {
    ST_PLAY = 2'd0,
    ST_HIT  = 2'd1,
    ST_OVER = 2'd2
  } state_t;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/ghost_collision_ctrl_tile_hit_cmp.sv
// tile_hit_cmp: flags a catch when a ghost shares the player tile or the two swapped tiles in one step.
module tile_hit_cmp
    import ghost_collision_ctrl_pkg::*;
(
    input  logic [WIDTH_LOG2-1:0]  gx,
    input  logic [HEIGHT_LOG2-1:0] gy,
    input  logic [WIDTH_LOG2-1:0]  px,
    input  logic [HEIGHT_LOG2-1:0] py,
    input  logic [WIDTH_LOG2-1:0]  ppx,
    input  logic [HEIGHT_LOG2-1:0] ppy,
    input  logic [WIDTH_LOG2-1:0]  pgx,
    input  logic [HEIGHT_LOG2-1:0] pgy,
    input  logic                   prev_valid,
    output logic                   hit
);
    logic same, swap;

    always_comb begin
        same = (gx == px) && (gy == py);
        swap = prev_valid && (gx == ppx) && (gy == ppy) && (px == pgx) && (py == pgy);
        hit  = same | swap;
    end
endmodule

// File: rtl/ghost_collision_ctrl.sv
// ghost_collision_ctrl: per-step catch detection, lives, freeze/respawn sequencing and game-over hold.
module ghost_collision_ctrl
    import ghost_collision_ctrl_pkg::*;
#(
    parameter int NUM_GHOSTS   = 4,
    parameter int LIVES_INIT   = 3,
    parameter int FREEZE_STEPS = 8,
    localparam int CW = id_width(NUM_GHOSTS)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              step,
    input  logic                              start,
    input  logic [WIDTH_LOG2-1:0]             player_x,
    input  logic [HEIGHT_LOG2-1:0]            player_y,
    input  logic [NUM_GHOSTS*WIDTH_LOG2-1:0]  ghost_xs,
    input  logic [NUM_GHOSTS*HEIGHT_LOG2-1:0] ghost_ys,
    output logic [1:0]                        lives,
    output logic                              caught,
    output logic [CW-1:0]                     caught_id,
    output logic                              freeze,
    output logic                              respawn,
    output logic                              game_over
);
    state_t                            state, state_n;
    logic [3:0]                        cnt, cnt_n;
    logic [1:0]                        lives_n;
    logic [CW-1:0]                     cid_n, hit_id;
    logic                              caught_n, freeze_n, respawn_n, over_n;
    logic                              prev_valid, pv_n, cap;
    logic [WIDTH_LOG2-1:0]             prev_px;
    logic [HEIGHT_LOG2-1:0]            prev_py;
    logic [NUM_GHOSTS*WIDTH_LOG2-1:0]  prev_gxs;
    logic [NUM_GHOSTS*HEIGHT_LOG2-1:0] prev_gys;
    logic [NUM_GHOSTS-1:0]             hit;

    for (genvar g = 0; g < NUM_GHOSTS; g++) begin : g_cmp
        tile_hit_cmp u_cmp (
            .gx        (ghost_xs[g*WIDTH_LOG2 +: WIDTH_LOG2]),
            .gy        (ghost_ys[g*HEIGHT_LOG2 +: HEIGHT_LOG2]),
            .px        (player_x),
            .py        (player_y),
            .ppx       (prev_px),
            .ppy       (prev_py),
            .pgx       (prev_gxs[g*WIDTH_LOG2 +: WIDTH_LOG2]),
            .pgy       (prev_gys[g*HEIGHT_LOG2 +: HEIGHT_LOG2]),
            .prev_valid(prev_valid),
            .hit       (hit[g])
        );
    end

    // Descending scan so the lowest hitting index wins.
    always_comb begin
        hit_id = '0;
        for (int i = NUM_GHOSTS - 1; i >= 0; i--)
            if (hit[i]) hit_id = CW'(i);
    end

    always_comb begin
        state_n   = state;
        lives_n   = lives;
        cnt_n     = cnt;
        cid_n     = caught_id;
        freeze_n  = freeze;
        over_n    = game_over;
        pv_n      = prev_valid;
        caught_n  = 1'b0;
        respawn_n = 1'b0;
        cap       = 1'b0;
        case (state)
            ST_PLAY: if (step) begin
                cap  = 1'b1;
                pv_n = 1'b1;
                if (|hit) begin
                    caught_n = 1'b1;
                    cid_n    = hit_id;
                    lives_n  = lives - 2'd1;
                    pv_n     = 1'b0;
                    freeze_n = 1'b1;
                    cnt_n    = '0;
                    state_n  = (lives_n == 2'd0) ? ST_OVER : ST_HIT;
                    over_n   = (lives_n == 2'd0);
                end
            end
            ST_HIT: if (step) begin
                if (cnt == 4'(FREEZE_STEPS - 1)) begin
                    state_n   = ST_PLAY;
                    freeze_n  = 1'b0;
                    respawn_n = 1'b1;
                end else begin
                    cnt_n = cnt + 4'd1;
                end
            end
            ST_OVER: if (start) begin
                state_n   = ST_PLAY;
                lives_n   = 2'(LIVES_INIT);
                respawn_n = 1'b1;
                freeze_n  = 1'b0;
                over_n    = 1'b0;
                pv_n      = 1'b0;
            end
            default: state_n = ST_PLAY;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_PLAY;
            lives      <= 2'(LIVES_INIT);
            cnt        <= '0;
            caught     <= 1'b0;
            caught_id  <= '0;
            freeze     <= 1'b0;
            respawn    <= 1'b0;
            game_over  <= 1'b0;
            prev_valid <= 1'b0;
            prev_px    <= '0;
            prev_py    <= '0;
            prev_gxs   <= '0;
            prev_gys   <= '0;
        end else begin
            state      <= state_n;
            lives      <= lives_n;
            cnt        <= cnt_n;
            caught     <= caught_n;
            caught_id  <= cid_n;
            freeze     <= freeze_n;
            respawn    <= respawn_n;
            game_over  <= over_n;
            prev_valid <= pv_n;
            if (cap) begin
                prev_px  <= player_x;
                prev_py  <= player_y;
                prev_gxs <= ghost_xs;
                prev_gys <= ghost_ys;
            end
        end
    end
endmodule

// File: tb/tb_ghost_collision_ctrl.sv
// tb_ghost_collision_ctrl: directed scenarios for catch detection, freeze/respawn, game-over and reset.
module tb_ghost_collision_ctrl;
    import ghost_collision_ctrl_pkg::*;

    localparam int NG = 4;
    localparam int WW = WIDTH_LOG2;
    localparam int HW = HEIGHT_LOG2;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             step = 1'b0;
    logic             start = 1'b0;
    logic [WW-1:0]    player_x = '0;
    logic [HW-1:0]    player_y = '0;
    logic [NG*WW-1:0] ghost_xs = '0;
    logic [NG*HW-1:0] ghost_ys = '0;
    logic [1:0]       lives;
    logic             caught;
    logic [1:0]       caught_id;
    logic             freeze;
    logic             respawn;
    logic             game_over;

    int checks = 0;
    int fails = 0;

    ghost_collision_ctrl #(.NUM_GHOSTS(NG), .LIVES_INIT(3), .FREEZE_STEPS(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .step     (step),
        .start    (start),
        .player_x (player_x),
        .player_y (player_y),
        .ghost_xs (ghost_xs),
        .ghost_ys (ghost_ys),
        .lives    (lives),
        .caught   (caught),
        .caught_id(caught_id),
        .freeze   (freeze),
        .respawn  (respawn),
        .game_over(game_over)
    );

    always #5 clk = ~clk;

    task automatic set_ghost(input int i, input int x, input int y);
        ghost_xs[i*WW +: WW] = WW'(x);
        ghost_ys[i*HW +: HW] = HW'(y);
    endtask

    task automatic set_player(input int x, input int y);
        player_x = WW'(x);
        player_y = HW'(y);
    endtask

    task automatic park_all();
        for (int i = 0; i < NG; i++) set_ghost(i, 500 + 20 * i, 400);
    endtask

    task automatic do_step();
        @(negedge clk) step = 1'b1;
        @(negedge clk) step = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic run_freeze();
        for (int i = 0; i < 8; i++) do_step();
    endtask

    task automatic test_reset();
        park_all();
        set_player(10, 10);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++; if (lives !== 2'd3) begin fails++; $display("FAIL reset_lives: got %0d exp 3", lives); end
        checks++; if ({caught, caught_id, freeze, respawn, game_over} !== 6'b0) begin
            fails++; $display("FAIL reset_flags: got c=%b id=%0d f=%b r=%b go=%b exp all 0", caught, caught_id, freeze, respawn, game_over);
        end
    endtask

    task automatic test_same_tile();
        set_player(100, 100);
        set_ghost(0, 100, 100);
        do_step();
        checks++; if (caught !== 1'b1) begin fails++; $display("FAIL same_caught: got %b exp 1", caught); end
        checks++; if (caught_id !== 2'd0) begin fails++; $display("FAIL same_id: got %0d exp 0", caught_id); end
        checks++; if (lives !== 2'd2) begin fails++; $display("FAIL same_lives: got %0d exp 2", lives); end
        checks++; if (freeze !== 1'b1) begin fails++; $display("FAIL same_freeze: got %b exp 1", freeze); end
        @(negedge clk);
        checks++; if (caught !== 1'b0) begin fails++; $display("FAIL same_pulse: got %b exp 0", caught); end
        park_all();
        set_ghost(1, 100, 100);
        for (int i = 0; i < 7; i++) begin
            do_step();
            checks++; if (caught !== 1'b0 || respawn !== 1'b0 || freeze !== 1'b1) begin
                fails++; $display("FAIL hit_hold%0d: got c=%b r=%b f=%b exp c=0 r=0 f=1", i, caught, respawn, freeze);
            end
        end
        do_step();
        checks++; if (respawn !== 1'b1 || freeze !== 1'b0) begin
            fails++; $display("FAIL respawn_at8: got r=%b f=%b exp r=1 f=0", respawn, freeze);
        end
        checks++; if (lives !== 2'd2) begin fails++; $display("FAIL hit_no_loss: got %0d exp 2", lives); end
        @(negedge clk);
        checks++; if (respawn !== 1'b0) begin fails++; $display("FAIL respawn_pulse: got %b exp 0", respawn); end
        park_all();
    endtask

    task automatic test_start_ignored();
        pulse_start();
        checks++; if (lives !== 2'd2 || respawn !== 1'b0 || freeze !== 1'b0) begin
            fails++; $display("FAIL start_ignored: got l=%0d r=%b f=%b exp l=2 r=0 f=0", lives, respawn, freeze);
        end
    endtask

    task automatic test_swap();
        set_player(200, 60);
        set_ghost(2, 220, 60);
        do_step();
        checks++; if (caught !== 1'b0) begin fails++; $display("FAIL swap_pre: got %b exp 0", caught); end
        set_player(220, 60);
        set_ghost(2, 200, 60);
        do_step();
        checks++; if (caught !== 1'b1 || caught_id !== 2'd2) begin
            fails++; $display("FAIL swap_catch: got c=%b id=%0d exp c=1 id=2", caught, caught_id);
        end
        checks++; if (lives !== 2'd1) begin fails++; $display("FAIL swap_lives: got %0d exp 1", lives); end
        park_all();
        run_freeze();
        checks++; if (respawn !== 1'b1) begin fails++; $display("FAIL swap_respawn: got %b exp 1", respawn); end
    endtask

    task automatic test_multi_hit();
        set_player(300, 200);
        set_ghost(1, 300, 200);
        set_ghost(3, 300, 200);
        do_step();
        checks++; if (caught !== 1'b1 || caught_id !== 2'd1) begin
            fails++; $display("FAIL multi_id: got c=%b id=%0d exp c=1 id=1", caught, caught_id);
        end
        checks++; if (lives !== 2'd0) begin fails++; $display("FAIL multi_lives: got %0d exp 0", lives); end
        checks++; if (game_over !== 1'b1 || freeze !== 1'b1) begin
            fails++; $display("FAIL over_enter: got go=%b f=%b exp 1 1", game_over, freeze);
        end
    endtask

    task automatic test_game_over();
        for (int i = 0; i < 3; i++) begin
            do_step();
            checks++; if (caught !== 1'b0 || lives !== 2'd0 || game_over !== 1'b1) begin
                fails++; $display("FAIL over_hold%0d: got c=%b l=%0d go=%b exp c=0 l=0 go=1", i, caught, lives, game_over);
            end
        end
        park_all();
        pulse_start();
        checks++; if (lives !== 2'd3 || respawn !== 1'b1) begin
            fails++; $display("FAIL restart: got l=%0d r=%b exp l=3 r=1", lives, respawn);
        end
        checks++; if (game_over !== 1'b0 || freeze !== 1'b0) begin
            fails++; $display("FAIL restart_flags: got go=%b f=%b exp 0 0", game_over, freeze);
        end
    endtask

    task automatic test_swap_after_respawn();
        set_player(300, 300);
        set_ghost(0, 300, 300);
        set_ghost(3, 340, 300);
        do_step();
        checks++; if (caught !== 1'b1 || caught_id !== 2'd0 || lives !== 2'd2) begin
            fails++; $display("FAIL sar_catch: got c=%b id=%0d l=%0d exp c=1 id=0 l=2", caught, caught_id, lives);
        end
        set_ghost(0, 500, 400);
        run_freeze();
        set_player(340, 300);
        set_ghost(3, 300, 300);
        do_step();
        checks++; if (caught !== 1'b0 || lives !== 2'd2) begin
            fails++; $display("FAIL sar_nocheck: got c=%b l=%0d exp c=0 l=2", caught, lives);
        end
        set_player(300, 300);
        set_ghost(3, 340, 300);
        do_step();
        checks++; if (caught !== 1'b1 || caught_id !== 2'd3 || lives !== 2'd1) begin
            fails++; $display("FAIL sar_swap: got c=%b id=%0d l=%0d exp c=1 id=3 l=1", caught, caught_id, lives);
        end
        park_all();
    endtask

    task automatic test_reset_mid_hit();
        repeat (4) do_step();
        #2 reset = 1'b0;
        #1;
        checks++; if (lives !== 2'd3 || freeze !== 1'b0 || respawn !== 1'b0 || game_over !== 1'b0) begin
            fails++; $display("FAIL mid_reset: got l=%0d f=%b r=%b go=%b exp l=3 f=0 r=0 go=0", lives, freeze, respawn, game_over);
        end
        @(negedge clk) reset = 1'b1;
        set_player(50, 50);
        set_ghost(2, 50, 50);
        do_step();
        checks++; if (caught !== 1'b1 || caught_id !== 2'd2 || lives !== 2'd2) begin
            fails++; $display("FAIL post_reset_play: got c=%b id=%0d l=%0d exp c=1 id=2 l=2", caught, caught_id, lives);
        end
    endtask

    initial begin
        test_reset();
        test_same_tile();
        test_start_ignored();
        test_swap();
        test_multi_hit();
        test_game_over();
        test_swap_after_respawn();
        test_reset_mid_hit();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
